// File: rtl/phy_pkg.sv
// Shared PCS constants for the block path: block length, sync header codes
// and the lock-state encoding used by the block-lock FSM.
package phy_pkg;

    localparam int         BLOCK_W   = 130;
    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_OS   = 2'b01;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_VERIFY,
        ST_LOCKED
    } lock_state_e;

    function automatic logic hdr_is_valid(input logic [1:0] hdr);
        return (hdr == SYNC_DATA) || (hdr == SYNC_OS);
    endfunction

endpackage

// File: rtl/block_lock_fsm.sv
// Block-lock state machine: counts consecutive good/bad sync headers,
// requests bit slips while hunting and flags blocks that may be emitted.
module block_lock_fsm
    import phy_pkg::*;
#(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_blk_done,
    input  logic i_hdr_valid,
    output logic o_emit,
    output logic o_slip,
    output logic o_locked
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(UNLOCK_CNT + 1);

    lock_state_e   r_state, w_state_next;
    logic [GW-1:0] r_good_cnt, w_good_next, w_good_inc;
    logic [BW-1:0] r_bad_cnt, w_bad_next, w_bad_inc;

    assign w_good_inc = r_good_cnt + GW'(1);
    assign w_bad_inc  = r_bad_cnt + BW'(1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_HUNT;
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_good_cnt <= w_good_next;
            r_bad_cnt  <= w_bad_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_good_next  = r_good_cnt;
        w_bad_next   = r_bad_cnt;
        o_emit       = 1'b0;
        o_slip       = 1'b0;
        if (i_blk_done) begin
            case (r_state)
                ST_HUNT: begin
                    if (i_hdr_valid) begin
                        w_state_next = ST_VERIFY;
                        w_good_next  = GW'(1);
                    end else begin
                        o_slip = 1'b1;
                    end
                end
                ST_VERIFY: begin
                    if (i_hdr_valid) begin
                        w_good_next = w_good_inc;
                        if (w_good_inc >= GW'(LOCK_CNT)) begin
                            w_state_next = ST_LOCKED;
                            w_bad_next   = '0;
                        end
                    end else begin
                        w_state_next = ST_HUNT;
                        w_good_next  = '0;
                        o_slip       = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    // The block that drops lock is still emitted.
                    o_emit = 1'b1;
                    if (i_hdr_valid) begin
                        w_bad_next = '0;
                    end else if (w_bad_inc >= BW'(UNLOCK_CNT)) begin
                        w_state_next = ST_HUNT;
                        w_good_next  = '0;
                        w_bad_next   = '0;
                        o_slip       = 1'b1;
                    end else begin
                        w_bad_next = w_bad_inc;
                    end
                end
                default: begin
                    w_state_next = ST_HUNT;
                end
            endcase
        end
    end

    assign o_locked = (r_state == ST_LOCKED);

endmodule

// File: rtl/block_deserializer.sv
// Serial-to-parallel block deserializer with sync-header block lock.
// Bits arrive MSB first; locked blocks are emitted one cycle after completion.
module block_deserializer
    import phy_pkg::*;
#(
    parameter int WIDTH      = BLOCK_W,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ser_in,
    input  logic             ser_valid,
    output logic [WIDTH-1:0] par_out,
    output logic             par_valid,
    output logic             hdr_err,
    output logic             locked
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_bit_cnt;
    logic             r_slip;
    logic [WIDTH-1:0] r_par_out;
    logic             r_par_valid;
    logic             r_hdr_err;

    logic [WIDTH-1:0] w_shift_next;
    logic             w_accept;
    logic             w_blk_done;
    logic             w_hdr_valid;
    logic             w_emit;
    logic             w_slip_req;
    logic             w_locked;

    assign w_shift_next = {r_shift[WIDTH-2:0], ser_in};
    assign w_accept     = ser_valid && !r_slip;
    assign w_blk_done   = w_accept && (r_bit_cnt == CW'(WIDTH - 1));
    assign w_hdr_valid  = hdr_is_valid(w_shift_next[WIDTH-1:WIDTH-2]);

    block_lock_fsm #(
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT)
    ) u_lock_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_blk_done  (w_blk_done),
        .i_hdr_valid (w_hdr_valid),
        .o_emit      (w_emit),
        .o_slip      (w_slip_req),
        .o_locked    (w_locked)
    );

    // A pending slip swallows the next accepted bit, moving the boundary later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_slip    <= 1'b0;
        end else if (ser_valid) begin
            if (r_slip) begin
                r_slip <= 1'b0;
            end else begin
                r_shift   <= w_shift_next;
                r_bit_cnt <= w_blk_done ? '0 : r_bit_cnt + CW'(1);
                r_slip    <= w_slip_req;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_out   <= '0;
            r_par_valid <= 1'b0;
            r_hdr_err   <= 1'b0;
        end else begin
            r_par_valid <= w_emit;
            if (w_emit) begin
                r_par_out <= w_shift_next;
                r_hdr_err <= !w_hdr_valid;
            end
        end
    end

    assign par_out   = r_par_out;
    assign par_valid = r_par_valid;
    assign hdr_err   = r_hdr_err;
    assign locked    = w_locked;

endmodule

// File: doc/block_deserializer.md
BLOCK_DESERIALIZER -- requirements
Module: block_deserializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 130, giving the block length in bits including the 2-bit sync header.
REQ-002 The block SHALL have parameter LOCK_CNT, default 4, giving the number of consecutive valid headers needed to reach lock.
REQ-003 The block SHALL have parameter UNLOCK_CNT, default 4, giving the number of consecutive invalid headers that forces loss of lock.
REQ-004 Port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port ser_in, input, 1 bit: serial bit stream, MSB of each block first, matching the transmit serializer.
REQ-007 Port ser_valid, input, 1 bit: ser_in is sampled only in cycles where this is high.
REQ-008 Port par_out, output, WIDTH bits: assembled block; the first-received bit is at par_out[WIDTH-1].
REQ-009 Port par_valid, output, 1 bit: one-cycle pulse qualifying par_out.
REQ-010 Port hdr_err, output, 1 bit: qualifies par_out and is high when par_out[WIDTH-1:WIDTH-2] is an invalid header.
REQ-011 Port locked, output, 1 bit: high while the FSM is in LOCKED.

Function
REQ-012 Every accepted bit SHALL shift into a WIDTH-bit register and advance a bit counter 0..WIDTH-1; stalled cycles change nothing.
REQ-013 A block SHALL complete on the accepted bit taken when the counter equals WIDTH-1; the counter then wraps to 0.
REQ-014 A header is valid only if it equals 2'b10 (data) or 2'b01 (ordered set); 2'b00 and 2'b11 are invalid.
REQ-015 The FSM SHALL have exactly three states: HUNT, VERIFY and LOCKED.
REQ-016 HUNT, valid header: go to VERIFY with good_cnt=1.
REQ-017 HUNT, invalid header: stay in HUNT and perform a slip.
REQ-018 Slip: the next accepted bit is discarded without shifting or counting, moving the block boundary one bit later.
REQ-019 VERIFY, valid header: increment good_cnt; on reaching LOCK_CNT, go to LOCKED with bad_cnt=0.
REQ-020 VERIFY, invalid header: go to HUNT, clear good_cnt and slip.
REQ-021 LOCKED, valid header: clear bad_cnt.
REQ-022 LOCKED, invalid header: increment bad_cnt; on reaching UNLOCK_CNT, go to HUNT and slip.
REQ-023 par_valid SHALL pulse only for blocks completed while in LOCKED, including the block that causes the exit to HUNT.
REQ-024 par_out, hdr_err and par_valid SHALL be registered, appearing in the cycle after the completing bit is sampled (latency 1 clk).
REQ-025 par_out and hdr_err SHALL hold their values between pulses.
REQ-026 locked SHALL change in the same cycle as the par_valid pulse of the deciding block.
REQ-027 No block is ever emitted in HUNT or VERIFY.
REQ-028 Back-to-back blocks with ser_valid continuously high SHALL produce par_valid exactly every WIDTH cycles, with no lost bit.

Reset
REQ-029 While rst_n is low: state=HUNT, counters=0, shift register=0, pending slip cleared, par_out=0, par_valid=0, hdr_err=0, locked=0.
REQ-030 Reset asserted mid-block SHALL discard the partial block, and no pulse SHALL occur afterwards until relock.

Structure
REQ-031 Shared package phy_pkg SHALL hold BLOCK_W=130, SYNC_DATA=2'b10, SYNC_OS=2'b01 and the lock-state enum type.
REQ-032 The lock FSM and its good/bad counters SHALL be a sub-module named block_lock_fsm; shifting and counting stay in the top level.

Verification
REQ-033 Aligned stream of 10 blocks, headers 10, continuous valid: locked rises with the 4th block's pulse; par_valid pulses for blocks 5-10, each 130 cycles apart, with par_out equal to the transmitted block.
REQ-034 Stream offset by 37 bits: the FSM slips until aligned and reaches lock within (37+4)*130 + 37 accepted bits; all later blocks are bit-exact.
REQ-035 Locked, then 3 headers 11 and one header 01: hdr_err=1 on three pulses, locked stays 1 and bad_cnt returns to 0.
REQ-036 Locked, then 4 consecutive headers 00: locked falls with the 4th pulse (hdr_err=1), followed by no pulses until relock.
REQ-037 ser_valid toggled randomly at 50% on an aligned stream: output blocks are identical to the continuous case and only pulse spacing changes.
REQ-038 rst_n asserted at bit 60 of a locked block: all outputs are 0 immediately; after release, relock needs 4 fresh valid headers.
